mux_pipe_stage: RTL and testbench
=================================

// Module: mux_pipe_stage
// PURPOSE
//  Parametrised NUM_IN-way, WIDTH-bit select stage with one pipeline register and a valid/ready handshake.
//  Successor to the plain 2:1 datapath mux; used for operand/forwarding selection between CPU pipeline stages.
//  Adds backpressure, flush and out-of-range select detection.
//  Optional skid buffer (MUX_SKID_EN) removes the combinational ready path.
// PARAMETERS
//  WIDTH   32  data width of each input and of the output
//  NUM_IN  4   number of data inputs, 2..16
//  SEL_W   2   select width; NUM_IN <= 2**SEL_W
// PORTS
//  clk       in   1              rising-edge clock, the only clock
//  rst       in   1              synchronous, active-high reset
//  flush     in   1              sync pipeline flush; drops held data
//  in_data   in   NUM_IN*WIDTH   packed inputs; input k = in_data[k*WIDTH +: WIDTH]
//  in_sel    in   SEL_W          input index
//  in_valid  in   1              upstream offers in_data/in_sel
//  in_ready  out  1              stage accepts this cycle
//  out_data  out  WIDTH          registered selected word
//  out_err   out  1              registered; 1 = in_sel was >= NUM_IN
//  out_valid out  1              out_data/out_err valid
//  out_ready in   1              downstream accepts this cycle
// BEHAVIOUR
//  - Handshakes:
//    - Accept when in_valid & in_ready.
//    - Pop when out_valid & out_ready.
//    - in_valid must be held with in_data and in_sel stable until accepted.
//  - Select and latency:
//    - Selection is combinational on the accepted beat and is captured in the output register.
//    - Latency is 1 cycle: a beat accepted on edge n is visible on out_* after edge n.
//  - Out-of-range select: in_sel >= NUM_IN stores out_data = 0 and out_err = 1. The beat is still delivered.
//  - Reset, checked first: rst high at an edge clears out_valid, out_data, out_err and the skid entry to 0.
//    - in_ready is 0 while rst is high, and the stage accepts nothing.
//  - Flush, checked second: flush high at an edge clears out_valid and the skid valid flag.
//    - A beat offered in the same cycle is dropped, not stored. in_ready is 0 while flush is high.
//  - Simultaneous pop and accept in FULL: the new beat replaces the popped one, with no bubble.
//  - Hold: when out_valid & ~out_ready, out_data and out_err stay stable.
// CONFIGURATION
//  - Macro MUX_SKID_EN undefined:
//    - Single register. States: EMPTY and FULL.
//    - in_ready = ~rst & ~flush & (~out_valid | out_ready). This is a combinational path from out_ready.
//    - Full throughput.
//  - Macro MUX_SKID_EN defined:
//    - Adds a one-entry skid register. States: EMPTY, FULL, SKID.
//    - in_ready is driven from a flop: 1 in EMPTY and FULL, 0 in SKID, 0 during rst and flush.
//    - Transitions:
//      - EMPTY -acc-> FULL.
//      - FULL -acc & ~pop-> SKID; the beat is stored in the skid register.
//      - FULL -pop & ~acc-> EMPTY.
//      - FULL -acc & pop-> FULL.
//      - SKID -pop-> FULL; the skid entry moves to the output register.
//    - No combinational in->out path. Throughput is 1 beat/cycle.
// STRUCTURE
//  - Shared package/include (mux_pkg.vh):
//    - ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2.
//    - Default WIDTH and SEL_W localparams.
//  - Sub-module mux_sel_n: purely combinational NUM_IN:1 select.
//    - Outputs the selected word and an out-of-range flag.
//    - Instanced once, feeding both the output register and the skid register.
//  - Control FSM and the registers live in mux_pipe_stage.
// TESTING (run each with MUX_SKID_EN defined and with it undefined)
//  1. Reset: hold rst 3 cycles with in_valid=1 -> out_valid=0, out_data=0, out_err=0, in_ready=0; nothing is accepted.
//  2. Streaming: inputs k=32'h1000_000k, sel 0,1,2,3 back-to-back, out_ready=1 -> outputs 10000000..10000003 in order.
//     - Each output appears 1 cycle after its accept. No bubbles.
//  3. Backpressure: out_ready=0 for 4 cycles mid-stream.
//     - out_data stays stable.
//     - Skid mode: exactly 1 extra beat is absorbed, then in_ready=0. No beat is lost or duplicated on release.
//  4. Range: NUM_IN=3, sel=3 -> out_data=0, out_err=1. Next sel=2 -> out_err=0, data = input 2.
//  5. Flush: flush high while FULL (and while SKID) with in_valid=1 -> out_valid=0 next cycle.
//     - The beat offered in the flush cycle never appears at the output.
//  6. Random: in_valid/out_ready each 50% random for 10k cycles. A scoreboard compares against a queue model.
//     - No loss, no reordering, no duplication.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the mux_pipe_stage select stage: FSM state encoding
// and default parameter values.
package mux_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_NUM_IN = 4;
  localparam int DEF_SEL_W  = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

endpackage

// File: rtl/mux_sel_n.sv
// Purely combinational NUM_IN:1 word select with an out-of-range flag.
// A select that matches no input yields a zero word and err_o = 1.
module mux_sel_n #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    err_o
);

  always_comb begin
    data_o = '0;
    err_o  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel_i == SEL_W'(k)) begin
        data_o = data_i[k*WIDTH +: WIDTH];
        err_o  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_pipe_stage.sv
// NUM_IN-way select stage with one output register and valid/ready handshake.
// Define MUX_SKID_EN to add a one-entry skid register so in_ready comes from state only.
module mux_pipe_stage
  import mux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W  = DEF_SEL_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              state_o
);

  // Handshake: a beat is accepted when in_valid & in_ready and popped when
  // out_valid & out_ready, both at the rising edge; upstream holds data until accepted.

  state_e state_q, state_d;
  logic   acc, pop;

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;

  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
`ifdef MUX_SKID_EN
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_err_q, skid_err_d;
`endif

  mux_sel_n #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_sel (
    .data_i (in_data),
    .sel_i  (in_sel),
    .data_o (sel_data),
    .err_o  (sel_err)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (acc) state_d = ST_FULL;
        ST_FULL: begin
`ifdef MUX_SKID_EN
          if (acc && !pop)      state_d = ST_SKID;
          else if (pop && !acc) state_d = ST_EMPTY;
`else
          if (pop && !acc) state_d = ST_EMPTY;
`endif
        end
`ifdef MUX_SKID_EN
        ST_SKID: if (pop) state_d = ST_FULL;
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Skid build: ready depends only on the state flop, never on out_ready.
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    pop       = out_valid & out_ready;
`ifdef MUX_SKID_EN
    in_ready  = ~rst & ~flush & (state_q != ST_SKID);
`else
    in_ready  = ~rst & ~flush & (~out_valid | out_ready);
`endif
    acc       = in_valid & in_ready;
    state_o   = state_q;
  end

  always_comb begin
    data_d = data_q;
    err_d  = err_q;
`ifdef MUX_SKID_EN
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    if (state_q == ST_SKID && pop) begin
      data_d = skid_data_q;
      err_d  = skid_err_q;
    end else if (acc && (state_q == ST_EMPTY || pop)) begin
      data_d = sel_data;
      err_d  = sel_err;
    end else if (acc) begin
      skid_data_d = sel_data;
      skid_err_d  = sel_err;
    end
`else
    if (acc) begin
      data_d = sel_data;
      err_d  = sel_err;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      err_q  <= 1'b0;
`ifdef MUX_SKID_EN
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
`endif
    end else begin
      data_q <= data_d;
      err_q  <= err_d;
`ifdef MUX_SKID_EN
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
`endif
    end
  end

  assign out_data = data_q;
  assign out_err  = err_q;

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Self-checking bench for mux_pipe_stage (4-input instance) plus a 3-input
// instance for out-of-range selects; works with MUX_SKID_EN defined or not.
module tb_mux_pipe_stage;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int N3 = 3;
  localparam int SW = 2;
`ifdef MUX_SKID_EN
  localparam int SKID_EXTRA = 1;
`else
  localparam int SKID_EXTRA = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1, flush = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic [SW-1:0]  in_sel = '0;
  logic           in_valid = 1'b0, in_ready, out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic           out_err, out_valid;
  logic [1:0]     dbg_state;

  logic [N3*W-1:0] in_data3 = '0;
  logic [SW-1:0]   in_sel3 = '0;
  logic            in_valid3 = 1'b0, in_ready3, out_ready3 = 1'b0;
  logic [W-1:0]    out_data3;
  logic            out_err3, out_valid3;
  logic [1:0]      dbg_state3;

  int tests_run = 0;
  int tests_failed = 0;
  logic [W:0] exp_q[$];

  mux_pipe_stage #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready), .state_o(dbg_state)
  );

  mux_pipe_stage #(.WIDTH(W), .NUM_IN(N3), .SEL_W(SW)) u_dut3 (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data3), .in_sel(in_sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3), .out_err(out_err3),
    .out_valid(out_valid3), .out_ready(out_ready3), .state_o(dbg_state3)
  );

  function automatic logic [W:0] model(input logic [N*W-1:0] d, input logic [SW-1:0] s);
    if (int'(s) < N) return {1'b0, d[int'(s)*W +: W]};
    return {1'b1, {W{1'b0}}};
  endfunction

  // Scoreboard: push on accept, pop/compare on output handshake, check hold stability.
  initial begin
    logic       hold_prev;
    logic [W:0] hold_val, e;
    hold_prev = 1'b0;
    hold_val  = '0;
    forever begin
      @(negedge clk);
      if (rst || flush) begin
        exp_q.delete();
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          tests_run++;
          if ({out_valid, out_err, out_data} !== {1'b1, hold_val}) begin
            tests_failed++;
            $display("FAIL hold: got v=%0b err=%0b data=%h, need v=1 err=%0b data=%h",
                     out_valid, out_err, out_data, hold_val[W], hold_val[W-1:0]);
          end
        end
        if (out_valid && out_ready) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL sb_extra: unexpected beat err=%0b data=%h", out_err, out_data);
          end else begin
            e = exp_q.pop_front();
            if ({out_err, out_data} !== e) begin
              tests_failed++;
              $display("FAIL sb_data: got err=%0b data=%h, need err=%0b data=%h",
                       out_err, out_data, e[W], e[W-1:0]);
            end
          end
        end
        if (in_valid && in_ready) exp_q.push_back(model(in_data, in_sel));
        hold_prev = out_valid && !out_ready;
        hold_val  = {out_err, out_data};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_beat(input int id);
    for (int k = 0; k < N; k++) in_data[k*W +: W] = 32'hB000_0000 | (id << 8) | k;
    in_sel = SW'(id % N);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'd1; in_data = {4{32'hDEAD_BEEF}};
    in_valid3 = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if ({in_ready, out_valid, out_err, out_data} !== {3'b000, 32'h0}) begin
        tests_failed++;
        $display("FAIL reset: got rdy=%0b v=%0b err=%0b data=%h, need 0 0 0 0",
                 in_ready, out_valid, out_err, out_data);
      end
      tests_run++;
      if ({in_ready3, out_valid3} !== 2'b00) begin
        tests_failed++;
        $display("FAIL reset3: got rdy=%0b v=%0b, need 0 0", in_ready3, out_valid3);
      end
    end
    in_valid = 1'b0; in_valid3 = 1'b0; rst = 1'b0;
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_noacc: got out_valid=%0b, need 0", out_valid);
    end
  endtask

  task automatic test_streaming();
    for (int k = 0; k < N; k++) in_data[k*W +: W] = 32'h1000_0000 + k;
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      in_sel = SW'(k); in_valid = 1'b1;
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream_ready: beat %0d got in_ready=%0b, need 1", k, in_ready);
      end
      tick();
      tests_run++;
      if ({out_valid, out_err, out_data} !== {2'b10, 32'h1000_0000 + k}) begin
        tests_failed++;
        $display("FAIL stream_out: beat %0d got v=%0b err=%0b data=%h, need 1 0 %h",
                 k, out_valid, out_err, out_data, 32'h1000_0000 + k);
      end
    end
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_drain: got out_valid=%0b, need 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    int         next_id, accepts;
    logic       acc;
    logic [W:0] first;
    out_ready = 1'b1; load_beat(0); in_valid = 1'b1;
    tick();
    out_ready = 1'b0; load_beat(1); next_id = 2; accepts = 0;
    first = {1'b0, 32'hB000_0000};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) begin accepts++; load_beat(next_id); next_id++; end
      tests_run++;
      if ({out_valid, out_err, out_data} !== {1'b1, first}) begin
        tests_failed++;
        $display("FAIL bp_hold: cycle %0d got v=%0b err=%0b data=%h, need 1 0 %h",
                 c, out_valid, out_err, out_data, first[W-1:0]);
      end
    end
    tests_run++;
    if (accepts !== SKID_EXTRA || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_absorb: got accepts=%0d in_ready=%0b, need %0d 0",
               accepts, in_ready, SKID_EXTRA);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) begin load_beat(next_id); next_id++; end
    end
    in_valid = 1'b0;
    repeat (4) tick();
    tests_run++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_drain: got pending=%0d out_valid=%0b, need 0 0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_range();
    for (int k = 0; k < N3; k++) in_data3[k*W +: W] = 32'hA0A0_0000 + k;
    in_sel3 = 2'd3; in_valid3 = 1'b1; out_ready3 = 1'b1;
    tick();
    tests_run++;
    if ({out_valid3, out_err3, out_data3} !== {2'b11, 32'h0}) begin
      tests_failed++;
      $display("FAIL range_oob: got v=%0b err=%0b data=%h, need 1 1 0",
               out_valid3, out_err3, out_data3);
    end
    in_sel3 = 2'd2;
    tick();
    tests_run++;
    if ({out_valid3, out_err3, out_data3} !== {2'b10, 32'hA0A0_0002}) begin
      tests_failed++;
      $display("FAIL range_ok: got v=%0b err=%0b data=%h, need 1 0 a0a00002",
               out_valid3, out_err3, out_data3);
    end
    in_valid3 = 1'b0;
    tick();
    tests_run++;
    if (out_valid3 !== 1'b0) begin
      tests_failed++;
      $display("FAIL range_drain: got out_valid=%0b, need 0", out_valid3);
    end
  endtask

  task automatic test_flush(input bit fill_skid);
    out_ready = 1'b0; load_beat(10); in_valid = 1'b1;
    tick();
    if (fill_skid) begin load_beat(11); tick(); end
    flush = 1'b1; load_beat(12);
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_ready: skid=%0b got in_ready=%0b, need 0", fill_skid, in_ready);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL flush_clear: skid=%0b got v=%0b state=%0d, need 0 0",
               fill_skid, out_valid, dbg_state);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL flush_ghost: skid=%0b cycle %0d got out_valid=%0b data=%h, need 0",
                 fill_skid, c, out_valid, out_data);
      end
    end
  endtask

  task automatic test_random();
    logic acc;
    acc = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!in_valid || acc) begin
        in_valid = 1'($urandom_range(0, 1));
        for (int k = 0; k < N; k++) in_data[k*W +: W] = $urandom;
        in_sel = SW'($urandom_range(0, N - 1));
      end
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    tests_run++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL random_drain: got pending=%0d out_valid=%0b, need 0 0", exp_q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_range();
    test_flush(1'b0);
`ifdef MUX_SKID_EN
    test_flush(1'b1);
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
